// File: rtl/req_ack_initiator.sv
// -----------------------------------------------------------------------------
// req_ack_initiator
//
// Upstream requester for the single-cycle req/ack responder stage. Accepts one
// command at a time on a valid/ready port and issues a single-cycle req pulse
// for it. It then waits up to TIMEOUT cycles for ack and re-issues req up to
// MAX_RETRY times. Finally it reports a one-cycle completion carrying the
// command tag and an error flag.
//
// Optional feature (compile-time macro REQ_ACK_STATS_EN):
//   When this macro is defined, three saturating statistics counters are added
//   as ports. They count successful completions, individual timeouts and acks
//   that arrive outside WAIT.
//
// Ports:
//   clk           in   1      clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   cmd_valid     in   1      command present
//   cmd_ready     out  1      initiator idle and able to accept a command
//   cmd_id        in   ID_W   command tag, captured on handshake
//   req           out  1      registered request pulse to the responder
//   ack           in   1      acknowledge pulse from the responder
//   done_valid    out  1      registered one-cycle completion strobe
//   done_id       out  ID_W   tag of the completed command
//   done_err      out  1      1 = retries exhausted without ack
//   busy          out  1      command in flight
//   stat_ok_cnt   out  CNT_W  [REQ_ACK_STATS_EN] commands completed with ack
//   stat_tmo_cnt  out  CNT_W  [REQ_ACK_STATS_EN] individual timeouts
//   stat_spur_cnt out  CNT_W  [REQ_ACK_STATS_EN] acks received outside WAIT
// -----------------------------------------------------------------------------
module req_ack_initiator #(
  parameter int ID_W      = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [ID_W-1:0] cmd_id,
  output logic            req,
  input  logic            ack,
  output logic            done_valid,
  output logic [ID_W-1:0] done_id,
  output logic            done_err,
  output logic            busy
`ifdef REQ_ACK_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_ok_cnt,
  output logic [CNT_W-1:0] stat_tmo_cnt,
  output logic [CNT_W-1:0] stat_spur_cnt
`endif
);

  localparam int TMR_W = (TIMEOUT >= 2) ? $clog2(TIMEOUT) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  // A one-cycle WAIT window would put the next req only 2 cycles after the
  // previous one, which is too close for the responder's self-clearing flop.
  generate
    if (TIMEOUT < 2 || CNT_W < 1) begin : g_bad_param
      $error("req_ack_initiator: TIMEOUT must be >= 2 and CNT_W >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retry;
  logic [ID_W-1:0]  id_q;

  logic wait_ack;
  logic wait_tmo;

  // Ack wins over a coincident timeout.
  assign wait_ack  = (state == S_WAIT) && ack;
  assign wait_tmo  = (state == S_WAIT) && !ack && (timer == TMR_LAST);
  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req        <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_err   <= 1'b0;
      busy       <= 1'b0;
      timer      <= '0;
      retry      <= '0;
      id_q       <= '0;
    end else begin
      req        <= 1'b0;
      done_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            id_q  <= cmd_id;
            retry <= '0;
            req   <= 1'b1;
            busy  <= 1'b1;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (wait_ack) begin
            done_valid <= 1'b1;
            done_id    <= id_q;
            done_err   <= 1'b0;
            state      <= S_DONE;
          end else if (wait_tmo) begin
            if (retry == RTY_MAX) begin
              done_valid <= 1'b1;
              done_id    <= id_q;
              done_err   <= 1'b1;
              state      <= S_DONE;
            end else begin
              // Re-entering REQ after a full WAIT window keeps req pulses at
              // least TIMEOUT+1 cycles apart, so the responder's flop is idle.
              retry <= retry + 1'b1;
              req   <= 1'b1;
              state <= S_REQ;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef REQ_ACK_STATS_EN
  logic spur_ack;

  // Acks in IDLE, REQ or DONE are stale or unsolicited; they only get counted.
  assign spur_ack = ack && (state != S_WAIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ok_cnt   <= '0;
      stat_tmo_cnt  <= '0;
      stat_spur_cnt <= '0;
    end else begin
      if (wait_ack) stat_ok_cnt   <= sat_inc(stat_ok_cnt);
      if (wait_tmo) stat_tmo_cnt  <= sat_inc(stat_tmo_cnt);
      if (spur_ack) stat_spur_cnt <= sat_inc(stat_spur_cnt);
    end
  end
`endif

endmodule
